// File: rtl/ps2_key_decoder.sv
// Turns the ps2_keyboard FIFO byte stream into make/break key events with E0/F0 folding.
// Event outputs appear one cycle after the byte is sampled; at most one pop per 3 cycles, waits on kb_ready.
module ps2_key_decoder (
   input  logic       clk,
   input  logic       clrn,
   input  logic [7:0] kb_data,
   input  logic       kb_ready,
   input  logic       kb_overflow,
   output logic       kb_nextdata_n,
   output logic       evt_valid,
   output logic [7:0] evt_code,
   output logic       evt_ext,
   output logic       evt_break,
   output logic       evt_repeat,
   output logic       key_down,
   output logic [7:0] held_code,
   output logic       held_ext,
   output logic [7:0] press_cnt,
   output logic       err
);

   typedef enum logic [1:0] {IDLE, POP, GAP} state_t;

   state_t state;
   logic   ext_pend;
   logic   brk_pend;
   logic   held_match;

   assign held_match = (held_ext == ext_pend) && (held_code == kb_data);

   always_ff @(posedge clk or negedge clrn) begin
      if (!clrn) begin
         state         <= IDLE;
         kb_nextdata_n <= 1'b1;
         ext_pend      <= 1'b0;
         brk_pend      <= 1'b0;
         evt_valid     <= 1'b0;
         evt_code      <= 8'h00;
         evt_ext       <= 1'b0;
         evt_break     <= 1'b0;
         evt_repeat    <= 1'b0;
         key_down      <= 1'b0;
         held_code     <= 8'h00;
         held_ext      <= 1'b0;
         press_cnt     <= 8'h00;
         err           <= 1'b0;
      end else begin
         evt_valid <= 1'b0;
         if (kb_overflow)
            err <= 1'b1;

         case (state)
            IDLE: begin
               if (kb_ready) begin
                  kb_nextdata_n <= 1'b0;
                  state         <= POP;
                  case (kb_data)
                     8'hE0: ext_pend <= 1'b1;
                     8'hF0: brk_pend <= 1'b1;
                     8'hE1: begin
                        ext_pend <= 1'b0;
                        brk_pend <= 1'b0;
                     end
                     8'h00, 8'hFF: begin
                        ext_pend <= 1'b0;
                        brk_pend <= 1'b0;
                        err      <= 1'b1;
                     end
                     default: begin
                        evt_valid <= 1'b1;
                        evt_code  <= kb_data;
                        evt_ext   <= ext_pend;
                        evt_break <= brk_pend;
                        ext_pend  <= 1'b0;
                        brk_pend  <= 1'b0;
                        if (brk_pend) begin
                           // Releasing an overridden key leaves the current held key alone.
                           evt_repeat <= 1'b0;
                           if (held_match)
                              key_down <= 1'b0;
                        end else if (key_down && held_match) begin
                           evt_repeat <= 1'b1;
                        end else begin
                           evt_repeat <= 1'b0;
                           key_down   <= 1'b1;
                           held_code  <= kb_data;
                           held_ext   <= ext_pend;
                           press_cnt  <= press_cnt + 8'd1;
                        end
                     end
                  endcase
               end
            end
            POP: begin
               kb_nextdata_n <= 1'b1;
               state         <= GAP;
            end
            // Lets the FIFO advance its read pointer before kb_ready is looked at again.
            GAP: state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_ps2_key_decoder.sv
// Directed bench for ps2_key_decoder: scan-code sequences with hand-computed expected outputs.
module tb_ps2_key_decoder;

   logic       clk = 1'b0;
   logic       clrn = 1'b0;
   logic [7:0] kb_data = 8'h00;
   logic       kb_ready = 1'b0;
   logic       kb_overflow = 1'b0;
   logic       kb_nextdata_n;
   logic       evt_valid;
   logic [7:0] evt_code;
   logic       evt_ext;
   logic       evt_break;
   logic       evt_repeat;
   logic       key_down;
   logic [7:0] held_code;
   logic       held_ext;
   logic [7:0] press_cnt;
   logic       err;

   int checks = 0;
   int errors = 0;
   int evt_cnt = 0;
   int pop_cnt = 0;
   logic got_evt;

   ps2_key_decoder dut (
      .clk(clk), .clrn(clrn), .kb_data(kb_data), .kb_ready(kb_ready),
      .kb_overflow(kb_overflow), .kb_nextdata_n(kb_nextdata_n),
      .evt_valid(evt_valid), .evt_code(evt_code), .evt_ext(evt_ext),
      .evt_break(evt_break), .evt_repeat(evt_repeat), .key_down(key_down),
      .held_code(held_code), .held_ext(held_ext), .press_cnt(press_cnt), .err(err)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (clrn) begin
         if (evt_valid) evt_cnt++;
         if (!kb_nextdata_n) pop_cnt++;
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Present one byte; kb_ready stays high through the POP cycle to show it is ignored there.
   task automatic send(input logic [7:0] b);
      @(negedge clk);
      kb_data  = b;
      kb_ready = 1'b1;
      @(negedge clk);
      got_evt = evt_valid;
      chk("pop_low", {31'd0, kb_nextdata_n}, 0);
      @(negedge clk);
      kb_ready = 1'b0;
      chk("pop_high", {31'd0, kb_nextdata_n}, 1);
      chk("evt_one_cycle", {31'd0, evt_valid}, 0);
   endtask

   initial begin
      int evt_base;
      int pop_base;

      // Reset values
      repeat (2) @(negedge clk);
      chk("rst_nextdata_n", {31'd0, kb_nextdata_n}, 1);
      chk("rst_evt_valid", {31'd0, evt_valid}, 0);
      chk("rst_key_down", {31'd0, key_down}, 0);
      chk("rst_press_cnt", {24'd0, press_cnt}, 0);
      chk("rst_err", {31'd0, err}, 0);
      chk("rst_evt_code", {24'd0, evt_code}, 0);
      clrn = 1'b1;

      // Press and release 1C
      evt_base = evt_cnt;
      pop_base = pop_cnt;
      send(8'h1C);
      chk("p1_evt", {31'd0, got_evt}, 1);
      chk("p1_code", {24'd0, evt_code}, 32'h1C);
      chk("p1_break", {31'd0, evt_break}, 0);
      chk("p1_press_cnt", {24'd0, press_cnt}, 1);
      chk("p1_key_down", {31'd0, key_down}, 1);
      send(8'hF0);
      chk("p1_f0_no_evt", {31'd0, got_evt}, 0);
      send(8'h1C);
      chk("p1_rel_evt", {31'd0, got_evt}, 1);
      chk("p1_rel_break", {31'd0, evt_break}, 1);
      chk("p1_rel_key_down", {31'd0, key_down}, 0);
      chk("p1_rel_held", {24'd0, held_code}, 32'h1C);
      chk("p1_evt_pulses", evt_cnt - evt_base, 2);
      chk("p1_pop_pulses", pop_cnt - pop_base, 3);

      // Typematic repeats of 1C
      send(8'h1C);
      chk("tm_first_repeat", {31'd0, evt_repeat}, 0);
      chk("tm_press_cnt", {24'd0, press_cnt}, 2);
      for (int i = 0; i < 3; i++) begin
         send(8'h1C);
         chk("tm_repeat", {31'd0, evt_repeat}, 1);
         chk("tm_repeat_cnt", {24'd0, press_cnt}, 2);
      end
      send(8'hF0);
      send(8'h1C);
      chk("tm_rel_repeat", {31'd0, evt_repeat}, 0);
      chk("tm_rel_key_down", {31'd0, key_down}, 0);

      // Extended key E0 75
      evt_base = evt_cnt;
      send(8'hE0);
      chk("ex_e0_no_evt", {31'd0, got_evt}, 0);
      send(8'h75);
      chk("ex_make_ext", {31'd0, evt_ext}, 1);
      chk("ex_make_break", {31'd0, evt_break}, 0);
      chk("ex_press_cnt", {24'd0, press_cnt}, 3);
      send(8'hE0);
      send(8'hF0);
      send(8'h75);
      chk("ex_rel_ext", {31'd0, evt_ext}, 1);
      chk("ex_rel_break", {31'd0, evt_break}, 1);
      chk("ex_rel_key_down", {31'd0, key_down}, 0);
      chk("ex_held_code", {24'd0, held_code}, 32'h75);
      chk("ex_held_ext", {31'd0, held_ext}, 1);
      chk("ex_evt_pulses", evt_cnt - evt_base, 2);
      send(8'h75);
      chk("ex_plain_ext", {31'd0, evt_ext}, 0);
      chk("ex_plain_press", {24'd0, press_cnt}, 4);
      chk("ex_plain_held_ext", {31'd0, held_ext}, 0);
      send(8'hF0);
      send(8'h75);
      chk("ex_plain_rel", {31'd0, key_down}, 0);

      // Rollover 1C then 32
      send(8'h1C);
      send(8'h32);
      chk("ro_press_cnt", {24'd0, press_cnt}, 6);
      send(8'hF0);
      send(8'h1C);
      chk("ro_old_rel_break", {31'd0, evt_break}, 1);
      chk("ro_held_code", {24'd0, held_code}, 32'h32);
      chk("ro_key_down", {31'd0, key_down}, 1);
      send(8'hF0);
      send(8'h32);
      chk("ro_rel_key_down", {31'd0, key_down}, 0);

      // E1 discards a pending E0
      send(8'hE0);
      send(8'hE1);
      chk("e1_no_evt", {31'd0, got_evt}, 0);
      chk("e1_no_err", {31'd0, err}, 0);
      send(8'h75);
      chk("e1_plain_ext", {31'd0, evt_ext}, 0);
      chk("e1_press_cnt", {24'd0, press_cnt}, 7);

      // Error byte
      send(8'h00);
      chk("err00_no_evt", {31'd0, got_evt}, 0);
      chk("err00_err", {31'd0, err}, 1);

      // Press counter wrap: 248 alternating presses bring 7 to 255
      for (int i = 0; i < 248; i++)
         send((i % 2 == 0) ? 8'h1C : 8'h32);
      chk("wrap_255", {24'd0, press_cnt}, 255);
      send(8'h1C);
      chk("wrap_0", {24'd0, press_cnt}, 0);
      send(8'h32);
      chk("wrap_1", {24'd0, press_cnt}, 1);

      // Reset while in POP with prefixes pending
      send(8'hE0);
      @(negedge clk);
      kb_data  = 8'hF0;
      kb_ready = 1'b1;
      @(negedge clk);
      chk("mid_pop_low", {31'd0, kb_nextdata_n}, 0);
      #1 clrn = 1'b0;
      kb_ready = 1'b0;
      #1;
      chk("mid_rst_nextdata_n", {31'd0, kb_nextdata_n}, 1);
      chk("mid_rst_press_cnt", {24'd0, press_cnt}, 0);
      chk("mid_rst_key_down", {31'd0, key_down}, 0);
      chk("mid_rst_held_code", {24'd0, held_code}, 0);
      chk("mid_rst_evt_code", {24'd0, evt_code}, 0);
      chk("mid_rst_err", {31'd0, err}, 0);
      @(negedge clk);
      clrn = 1'b1;
      send(8'h75);
      chk("post_rst_evt", {31'd0, got_evt}, 1);
      chk("post_rst_ext", {31'd0, evt_ext}, 0);
      chk("post_rst_break", {31'd0, evt_break}, 0);
      chk("post_rst_press", {24'd0, press_cnt}, 1);
      chk("post_rst_key_down", {31'd0, key_down}, 1);

      // Overflow pulse sets sticky err
      chk("ovf_before", {31'd0, err}, 0);
      @(negedge clk);
      kb_overflow = 1'b1;
      @(negedge clk);
      kb_overflow = 1'b0;
      chk("ovf_set", {31'd0, err}, 1);
      repeat (3) @(negedge clk);
      chk("ovf_sticky", {31'd0, err}, 1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
